svm_det_collect: RTL and testbench
==================================

SVM_DET_COLLECT -- requirements
Module: svm_det_collect

Interface
REQ-001 Parameter FEA_I, default 4, integer bits of SVM score.
REQ-002 Parameter FEA_F, default 28, fractional bits of SVM score; score width W = FEA_I+FEA_F.
REQ-003 Parameter SW_W, default 11, slide-window index width.
REQ-004 Parameter DEPTH, default 16, detection FIFO entries (power of two, >=2).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 i_valid  input  1  SVM score strobe, one window per pulse.
REQ-008 i_result  input  W  signed two's-complement SVM score.
REQ-009 i_sw_id  input  SW_W  slide-window index of i_result.
REQ-010 i_frame_end  input  1  single-cycle pulse marking the last window of a frame.
REQ-011 i_thresh  input  W  signed decision threshold, sampled every cycle.
REQ-012 o_valid  output  1  FIFO head entry valid.
REQ-013 o_ready  input  1  consumer accepts head entry when o_valid&o_ready.
REQ-014 o_sw_id  output  SW_W  head entry window index.
REQ-015 o_result  output  W  head entry score.
REQ-016 o_count  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-017 o_overflow  output  1  sticky: a detection was dropped in current frame.
REQ-018 o_frame_done  output  1  one-cycle pulse, cycle after i_frame_end.
REQ-019 o_det_num  output  SW_W+1  detections (accepted+dropped) in last completed frame.
REQ-020 o_max_result  output  W  highest score of last completed frame (see REQ-034).
REQ-021 o_max_sw_id  output  SW_W  window index of o_max_result.

Function
REQ-022 Detection = i_valid && signed(i_result) > signed(i_thresh); equality is not a detection.
REQ-023 Detection pushes {i_sw_id,i_result} if FIFO not full, or if full and a pop occurs the same cycle.
REQ-024 Detection with FIFO full and no pop is dropped; o_overflow sets next cycle.
REQ-025 FIFO first-word-fall-through: detection at cycle N into empty FIFO gives o_valid=1 with that entry at N+1.
REQ-026 Pop only when o_valid&o_ready; o_ready with empty FIFO has no effect.
REQ-027 Simultaneous push and pop keeps o_count unchanged; pointers wrap modulo DEPTH.
REQ-028 Frame detection counter increments on every detection, saturating at 2^(SW_W+1)-1.
REQ-029 On i_frame_end: o_det_num loads counter value including any same-cycle detection; counter clears to 0.
REQ-030 o_overflow clears on cycle after i_frame_end, unless a drop occurs in the i_frame_end cycle, then stays 1.
REQ-031 FIFO contents are not flushed at frame end.
REQ-032 o_det_num, o_max_result, o_max_sw_id hold until next o_frame_done.

Reset
REQ-033 During rst: FIFO empty, o_valid=0, o_count=0, o_overflow=0, o_frame_done=0, o_det_num=0, o_max_result=0, o_max_sw_id=0, counters cleared; o_sw_id/o_result=0.

Configuration
REQ-034 Macro SVM_DET_MAX_EN defined: per-frame running max of i_result over all i_valid windows (ties keep earliest), initialized to most-negative W value at frame start, latched to o_max_* at i_frame_end.
REQ-035 SVM_DET_MAX_EN undefined: no max logic; o_max_result and o_max_sw_id tied to 0; ports retained.

Structure
REQ-036 Shared package svm_pkg holds FEA_I, FEA_F, score width W, SW_W defaults.
REQ-037 FIFO storage/pointers in sub-module det_fifo; thresholding, frame counters, max tracking in top.

Verification
REQ-038 i_thresh=0, i_result=0x10000000 sw_id=5 one pulse -> o_valid=1 next cycle, o_sw_id=5, o_count=1.
REQ-039 i_result equal to i_thresh, and i_result=0xF0000000 with i_thresh=0 -> no push, o_count stays 0.
REQ-040 o_ready=0, 17 detections -> o_count=16, o_overflow=1, i_frame_end -> o_det_num=17, o_overflow=0 next.
REQ-041 FIFO full, detection and pop same cycle -> o_count stays 16, new entry last out, no overflow.
REQ-042 SVM_DET_MAX_EN: scores 1,7,7,3 at sw_id 0..3 then i_frame_end -> o_max_result=7, o_max_sw_id=1.
REQ-043 rst asserted mid-frame with 5 entries queued -> o_valid=0, o_count=0 immediately, o_det_num=0.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared defaults for the SVM detection collector: score format and window index width.
package svm_pkg;

  localparam int unsigned FEA_I = 4;
  localparam int unsigned FEA_F = 28;
  localparam int unsigned W     = FEA_I + FEA_F;
  localparam int unsigned SW_W  = 11;
  localparam int unsigned DEPTH = 16;

endpackage

// File: rtl/det_fifo.sv
// First-word-fall-through detection FIFO with register storage.
// The head entry is visible whenever the FIFO is non-empty.
module det_fifo #(
  parameter int unsigned DW    = 43,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          valid_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i && valid_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/svm_det_collect.sv
// Thresholds SVM window scores, queues detections and keeps per-frame statistics.
// Optional per-frame maximum tracking is enabled with `define SVM_DET_MAX_EN.
module svm_det_collect
  import svm_pkg::*;
#(
  parameter int unsigned FEA_I = svm_pkg::FEA_I,
  parameter int unsigned FEA_F = svm_pkg::FEA_F,
  parameter int unsigned SW_W  = svm_pkg::SW_W,
  parameter int unsigned DEPTH = svm_pkg::DEPTH,
  localparam int unsigned SC_W = FEA_I + FEA_F,
  localparam int unsigned CW   = $clog2(DEPTH) + 1,
  localparam int unsigned NW   = SW_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [SC_W-1:0] i_result,
  input  logic [SW_W-1:0] i_sw_id,
  input  logic            i_frame_end,
  input  logic [SC_W-1:0] i_thresh,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [SW_W-1:0] o_sw_id,
  output logic [SC_W-1:0] o_result,
  output logic [CW-1:0]   o_count,
  output logic            o_overflow,
  output logic            o_frame_done,
  output logic [NW-1:0]   o_det_num,
  output logic [SC_W-1:0] o_max_result,
  output logic [SW_W-1:0] o_max_sw_id
);

  localparam int unsigned EW = SW_W + SC_W;

  logic          det, pop, full, drop;
  logic [EW-1:0] head;
  logic [NW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NW-1:0] det_num_q, det_num_d;
  logic          ovf_q, ovf_d;
  logic          done_q;

  assign det  = i_valid && ($signed(i_result) > $signed(i_thresh));
  assign pop  = o_valid && o_ready;
  assign drop = det && full && !pop;

  det_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (det),
    .pop_i   (o_ready),
    .wdata_i ({i_sw_id, i_result}),
    .rdata_o (head),
    .valid_o (o_valid),
    .full_o  (full),
    .count_o (o_count)
  );

  assign o_sw_id  = head[EW-1:SC_W];
  assign o_result = head[SC_W-1:0];

  // Frame statistics; a detection in the frame-end cycle belongs to the closing frame.
  always_comb begin
    cnt_inc   = (det && (cnt_q != '1)) ? cnt_q + NW'(1) : cnt_q;
    cnt_d     = cnt_inc;
    det_num_d = det_num_q;
    ovf_d     = ovf_q | drop;
    if (i_frame_end) begin
      cnt_d     = '0;
      det_num_d = cnt_inc;
      ovf_d     = drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      det_num_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      det_num_q <= det_num_d;
      ovf_q     <= ovf_d;
      done_q    <= i_frame_end;
    end
  end

  assign o_det_num    = det_num_q;
  assign o_overflow   = ovf_q;
  assign o_frame_done = done_q;

`ifdef SVM_DET_MAX_EN
  localparam logic [SC_W-1:0] SCORE_MIN = {1'b1, {(SC_W-1){1'b0}}};

  logic [SC_W-1:0] run_max_q, run_max_d, cand_max;
  logic [SW_W-1:0] run_id_q, run_id_d, cand_id;
  logic            seen_q, seen_d;
  logic [SC_W-1:0] max_res_q, max_res_d;
  logic [SW_W-1:0] max_id_q, max_id_d;

  // Strict compare keeps the earliest window on ties.
  always_comb begin
    cand_max = run_max_q;
    cand_id  = run_id_q;
    if (i_valid && (!seen_q || ($signed(i_result) > $signed(run_max_q)))) begin
      cand_max = i_result;
      cand_id  = i_sw_id;
    end
    run_max_d = cand_max;
    run_id_d  = cand_id;
    seen_d    = seen_q | i_valid;
    max_res_d = max_res_q;
    max_id_d  = max_id_q;
    if (i_frame_end) begin
      max_res_d = cand_max;
      max_id_d  = cand_id;
      run_max_d = SCORE_MIN;
      run_id_d  = '0;
      seen_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max_q <= SCORE_MIN;
      run_id_q  <= '0;
      seen_q    <= 1'b0;
      max_res_q <= '0;
      max_id_q  <= '0;
    end else begin
      run_max_q <= run_max_d;
      run_id_q  <= run_id_d;
      seen_q    <= seen_d;
      max_res_q <= max_res_d;
      max_id_q  <= max_id_d;
    end
  end

  assign o_max_result = max_res_q;
  assign o_max_sw_id  = max_id_q;
`else
  assign o_max_result = '0;
  assign o_max_sw_id  = '0;
`endif

endmodule

// File: tb/tb_svm_det_collect.sv
// Directed self-checking bench for svm_det_collect (default parameters).
module tb_svm_det_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_result;
  logic [10:0] i_sw_id;
  logic        i_frame_end;
  logic [31:0] i_thresh;
  logic        o_valid;
  logic        o_ready;
  logic [10:0] o_sw_id;
  logic [31:0] o_result;
  logic [4:0]  o_count;
  logic        o_overflow;
  logic        o_frame_done;
  logic [11:0] o_det_num;
  logic [31:0] o_max_result;
  logic [10:0] o_max_sw_id;

  int total = 0;
  int bad   = 0;

  svm_det_collect dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_result     (i_result),
    .i_sw_id      (i_sw_id),
    .i_frame_end  (i_frame_end),
    .i_thresh     (i_thresh),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_sw_id      (o_sw_id),
    .o_result     (o_result),
    .o_count      (o_count),
    .o_overflow   (o_overflow),
    .o_frame_done (o_frame_done),
    .o_det_num    (o_det_num),
    .o_max_result (o_max_result),
    .o_max_sw_id  (o_max_sw_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] res, input logic [10:0] id);
    i_valid  = 1'b1;
    i_result = res;
    i_sw_id  = id;
    tick();
    i_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_result = '0; i_sw_id = '0;
    i_frame_end = 1'b0; i_thresh = '0; o_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_done", 64'(o_frame_done), 64'd0);
    chk("rst_detnum", 64'(o_det_num), 64'd0);
    chk("rst_max", 64'(o_max_result), 64'd0);
    chk("rst_maxid", 64'(o_max_sw_id), 64'd0);
    chk("rst_swid", 64'(o_sw_id), 64'd0);
    chk("rst_result", 64'(o_result), 64'd0);
    rst = 1'b0;
    tick();

    // Single detection falls through to the head on the next cycle.
    send(32'h1000_0000, 11'd5);
    chk("fwft_valid", 64'(o_valid), 64'd1);
    chk("fwft_swid", 64'(o_sw_id), 64'd5);
    chk("fwft_result", 64'(o_result), 64'h1000_0000);
    chk("fwft_count", 64'(o_count), 64'd1);
    o_ready = 1'b1;
    tick();
    chk("pop_count", 64'(o_count), 64'd0);
    chk("pop_valid", 64'(o_valid), 64'd0);
    tick();
    chk("pop_empty_noeffect", 64'(o_count), 64'd0);
    o_ready = 1'b0;

    // Equality and negative scores are not detections.
    i_thresh = 32'h1234_5678;
    send(32'h1234_5678, 11'd6);
    chk("eq_nopush", 64'(o_count), 64'd0);
    i_thresh = 32'h0;
    send(32'hF000_0000, 11'd7);
    chk("neg_nopush", 64'(o_count), 64'd0);

    i_frame_end = 1'b1; tick(); i_frame_end = 1'b0;
    chk("f0_done", 64'(o_frame_done), 64'd1);
    chk("f0_detnum", 64'(o_det_num), 64'd1);
    tick();
    chk("f0_done_pulse", 64'(o_frame_done), 64'd0);

    // Fill to 16, seventeenth detection is dropped.
    for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), 11'(i));
    chk("fill_count", 64'(o_count), 64'd16);
    chk("fill_noovf", 64'(o_overflow), 64'd0);
    send(32'h200, 11'd16);
    chk("full_count", 64'(o_count), 64'd16);
    chk("full_ovf", 64'(o_overflow), 64'd1);
    i_frame_end = 1'b1; tick(); i_frame_end = 1'b0;
    chk("f1_detnum", 64'(o_det_num), 64'd17);
    chk("f1_ovf_clear", 64'(o_overflow), 64'd0);
    chk("f1_noflush", 64'(o_count), 64'd16);

    // Push with simultaneous pop while full.
    o_ready = 1'b1;
    send(32'h300, 11'd100);
    chk("pp_count", 64'(o_count), 64'd16);
    chk("pp_noovf", 64'(o_overflow), 64'd0);
    for (int i = 1; i < 16; i++) begin
      chk("drain_swid", 64'(o_sw_id), 64'(i));
      tick();
    end
    chk("drain_last_swid", 64'(o_sw_id), 64'd100);
    chk("drain_last_res", 64'(o_result), 64'h300);
    tick();
    chk("drain_empty", 64'(o_count), 64'd0);
    o_ready = 1'b0;

    // Drop in the frame-end cycle keeps overflow set.
    for (int i = 0; i < 16; i++) send(32'h400, 11'(i));
    i_frame_end = 1'b1;
    send(32'h500, 11'd50);
    i_frame_end = 1'b0;
    chk("f2_detnum", 64'(o_det_num), 64'd18);
    chk("f2_ovf_keep", 64'(o_overflow), 64'd1);
    tick();
    chk("f2_ovf_sticky", 64'(o_overflow), 64'd1);
    i_frame_end = 1'b1; tick(); i_frame_end = 1'b0;
    chk("f3_detnum", 64'(o_det_num), 64'd0);
    chk("f3_ovf_clear", 64'(o_overflow), 64'd0);
    o_ready = 1'b1;
    repeat (16) tick();
    o_ready = 1'b0;
    chk("drain2_empty", 64'(o_count), 64'd0);

    // Running maximum, ties keep the earliest window.
    send(32'd1, 11'd0);
    send(32'd7, 11'd1);
    send(32'd7, 11'd2);
    send(32'd3, 11'd3);
    i_frame_end = 1'b1; tick(); i_frame_end = 1'b0;
    chk("f4_detnum", 64'(o_det_num), 64'd4);
`ifdef SVM_DET_MAX_EN
    chk("max_result", 64'(o_max_result), 64'd7);
    chk("max_swid", 64'(o_max_sw_id), 64'd1);
`else
    chk("max_result_off", 64'(o_max_result), 64'd0);
    chk("max_swid_off", 64'(o_max_sw_id), 64'd0);
`endif

    // Asynchronous reset mid-frame with five entries queued.
    send(32'd2, 11'd9);
    chk("pre_rst_count", 64'(o_count), 64'd5);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_count", 64'(o_count), 64'd0);
    chk("arst_detnum", 64'(o_det_num), 64'd0);
    chk("arst_max", 64'(o_max_result), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_count", 64'(o_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
